// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and widths for the program loader and its
//             word assembler (loader FSM states, word/byte widths).
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    // Loader sequencing: length header, data bytes, one write cycle per word,
    // trailing checksum, then a terminal good/bad state.
    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/program_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Packs a big-endian byte stream into 32-bit words. The first
//             byte of a word ends up in [31:24]. word_full flags the byte
//             that completes the current word.
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              clear,      // synchronous restart of the word
    input  logic              shift_en,   // accept byte_in this cycle
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        byte_cnt,
    output logic              word_full
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;

    // Shift in a new byte at the bottom; the counter wraps to 0 after byte 4.
    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            word_d     = '0;
            byte_cnt_d = 2'd0;
        end else if (shift_en) begin
            word_d     = {word_q[WORD_W-BYTE_W-1:0], byte_in};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Byte shift register and byte counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q     <= '0;
            byte_cnt_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word      = word_q;
    assign byte_cnt  = byte_cnt_q;
    assign word_full = shift_en && (byte_cnt_q == 2'd3);

endmodule : word_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Boot loader in front of the single-cycle MIPS core. Receives a
//             length-prefixed, XOR-checksummed byte frame, writes the packed
//             words into instruction memory and releases the core only after
//             the checksum matches.
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH_WORDS = 256,
    parameter int IDX_W           = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       addr_hold_q, addr_hold_d;
    logic [31:0]       wdata_hold_q, wdata_hold_d;

    logic              w_accept;
    logic              w_shift;
    logic              w_clear;
    logic              w_word_full;
    logic [15:0]       w_n_full;
    logic [31:0]       w_wr_addr;
    logic [WORD_W-1:0] w_word;
    logic [1:0]        w_byte_cnt;

    // Handshake and status decode straight from the state register.
    always_comb begin
        rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CSUM);
        im_we     = (state_q == WRITE);
        done      = (state_q == DONE);
        error     = (state_q == ERR);
        cpu_reset = (state_q != DONE);
    end

    assign w_accept  = rx_valid && rx_ready;
    assign w_shift   = w_accept && (state_q == DATA);
    assign w_clear   = reload && ((state_q == DONE) || (state_q == ERR));
    assign w_n_full  = {n_hi_q, rx_data};
    assign w_wr_addr = 32'({word_idx_q, 2'b00});

    // The write port shows live values in WRITE and the last write otherwise.
    assign im_addr  = im_we ? w_wr_addr : addr_hold_q;
    assign im_wdata = im_we ? w_word    : wdata_hold_q;

    word_assembler u_word_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .shift_en  (w_shift),
        .byte_in   (rx_data),
        .word      (w_word),
        .byte_cnt  (w_byte_cnt),
        .word_full (w_word_full)
    );

    // Next-state, checksum accumulation and word-index sequencing.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        n_d          = n_q;
        n_hi_d       = n_hi_q;
        csum_d       = csum_q;
        addr_hold_d  = im_we ? w_wr_addr : addr_hold_q;
        wdata_hold_d = im_we ? w_word    : wdata_hold_q;

        unique case (state_q)
            LEN_HI: begin
                if (w_accept) begin
                    n_hi_d  = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_accept) begin
                    n_d    = IDX_W'(w_n_full);
                    csum_d = csum_q ^ rx_data;
                    if (w_n_full > 16'(MEM_DEPTH_WORDS)) begin
                        state_d = ERR;
                    end else if (w_n_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    csum_d = csum_q ^ rx_data;
                    if (w_word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                if ((word_idx_q + IDX_W'(1)) == n_q) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end
            CSUM: begin
                if (w_accept) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
            DONE, ERR: begin
                if (reload) begin
                    state_d    = LEN_HI;
                    word_idx_d = '0;
                    n_d        = '0;
                    n_hi_d     = 8'd0;
                    csum_d     = 8'd0;
                end
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase
    end

    // Loader state registers; an asynchronous reset drops all load progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LEN_HI;
            word_idx_q   <= '0;
            n_q          <= '0;
            n_hi_q       <= 8'd0;
            csum_q       <= 8'd0;
            addr_hold_q  <= 32'd0;
            wdata_hold_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            n_q          <= n_d;
            n_hi_q       <= n_hi_d;
            csum_q       <= csum_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

endmodule : program_loader
`default_nettype wire
